data_cache_dm: RTL
==================

// Module: data_cache_dm
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage (*_2DC/*_fDC side)
//  and data memory (block side). Byte/half/word reads and writes from MEM; on a miss it writes back
//  the dirty victim, refills the 256-bit block, then completes the access.
//  Drives data_valid_fDC low to stall MEM. flush_2DC writes back and invalidates all lines before SYS.
// PARAMETERS
//  INDEX_BITS  5   line index width; NUM_LINES = 2**INDEX_BITS
//  Derived: offset = addr[4:0] (32-byte block), word = addr[4:2], index = addr[5+:INDEX_BITS],
//  TAG_BITS = 27-INDEX_BITS, tag = addr[31 -: TAG_BITS]
// PORTS
//  CLK                  in   1    clock, all state updates on posedge
//  RESET                in   1    synchronous, active-low reset
//  read_2DC             in   1    MEM read request, held stable until data_valid_fDC=1
//  write_2DC            in   1    MEM write request, held stable until data_valid_fDC=1
//  data_address_2DC     in   32   byte address of request
//  data_write_2DC       in   32   store data, right-justified
//  data_write_size_2DC  in   2    bytes to write: 1,2,3; 0 = 4
//  flush_2DC            in   1    request write-back + invalidate of whole cache
//  data_read_fDC        out  32   aligned word containing the addressed byte(s)
//  data_valid_fDC       out  1    access complete this cycle / cache idle
//  flush_done           out  1    1-cycle pulse when flush finished
//  data_address_2DM     out  32   block address to memory, low 5 bits always 0
//  dBlkRead             out  1    block read request
//  block_read_fDM       in   256  refill data
//  block_read_fDM_valid in   1    refill data valid this cycle
//  dBlkWrite            out  1    block write request
//  block_write_2DM      out  256  write-back data
//  block_write_fDM_valid in  1    write-back accepted this cycle
// BEHAVIOUR
//  - Reset (RESET=0 at edge): all valid/dirty bits cleared, FSM->IDLE, flush index=0.
//    dBlkRead=0, dBlkWrite=0, flush_done=0, data_valid_fDC=0 while RESET=0. Tag/data arrays not reset.
//    Reset mid-miss/flush abandons it; no partial line is installed.
//  - Block layout: word w at bits [32*w+31:32*w]. Big-endian: byte offset k at word bits [31-8k -: 8].
//  - FSM: IDLE, WB, REFILL, FL_SCAN, FL_WB.
//  - IDLE, no request: data_valid_fDC=1.
//    Hit (valid & tag match): data_valid_fDC=1 same cycle (0-cycle hit latency).
//    Read hit: data_read_fDC = addressed word, combinational.
//    Write hit: at the edge, update lanes k..k+n-1 (k=addr[1:0], n=size, 0->4) from the n least-significant
//    bytes of data_write_2DC; lanes past 3 ignored; set dirty.
//    read_2DC & write_2DC together is illegal (assertion); treat as write.
//  - IDLE miss: data_valid_fDC=0. Victim valid&dirty -> WB, else -> REFILL.
//  - WB: dBlkWrite=1, block_write_2DM=victim data, data_address_2DM={victim tag,index,5'b0},
//    all held until block_write_fDM_valid=1, then -> REFILL.
//  - REFILL: dBlkRead=1, data_address_2DM={addr[31:5],5'b0} until block_read_fDM_valid=1.
//    Then install block, tag, valid=1, dirty=0 and -> IDLE. Next cycle the held request hits.
//    A miss therefore costs WB cycles + REFILL cycles + 1.
//  - dBlkRead and dBlkWrite are never both 1. Outside WB/REFILL/FL_WB both are 0 and data_address_2DM=0.
//  - Flush: flush_2DC is sampled only in IDLE and has priority over a pending request.
//    FL_SCAN walks index 0..NUM_LINES-1, one line per cycle; a dirty line -> FL_WB (as WB), then resume.
//    Each visited line is invalidated and cleaned. After the last index: flush_done=1 for one cycle, -> IDLE.
//    data_valid_fDC=0 throughout the flush.
//  - Memory valid inputs are ignored in states that do not expect them.
// TESTING
//  1 Reset, read 0x00001004 -> dBlkRead until valid, refill word1=0xDEADBEEF; next cycle data_valid=1, data=0xDEADBEEF
//  2 Write size=1 data=0xAB to 0x00001006 (hit) -> word1 reads 0xDEADABEF; line dirty; no memory traffic
//  3 Read 0x00002004 (same index, new tag) -> dBlkWrite, addr 0x00001000, data word1=0xDEADABEF;
//    hold 3 cycles until block_write_fDM_valid; then dBlkRead, addr 0x00002000
//  4 Two dirty lines at index 0 and 31, flush_2DC=1 -> two write-backs in index order;
//    flush_done one pulse; then read 0x00001004 misses
//  5 RESET low during REFILL -> next edge dBlkRead=0; previous address then misses
//  6 Write size=0 0x11223344 to 0x00001008 after refill -> read returns 0x11223344; size=2 at offset 2 updates low half only

Source files
------------

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a 256-bit block interface.
// Misses write back a dirty victim, refill the block, then complete the held request on the next cycle.
module data_cache_dm #(
    parameter int INDEX_BITS = 5
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         read_2DC,
    input  logic         write_2DC,
    input  logic [31:0]  data_address_2DC,
    input  logic [31:0]  data_write_2DC,
    input  logic [1:0]   data_write_size_2DC,
    input  logic         flush_2DC,
    output logic [31:0]  data_read_fDC,
    output logic         data_valid_fDC,
    output logic         flush_done,
    output logic [31:0]  data_address_2DM,
    output logic         dBlkRead,
    input  logic [255:0] block_read_fDM,
    input  logic         block_read_fDM_valid,
    output logic         dBlkWrite,
    output logic [255:0] block_write_2DM,
    input  logic         block_write_fDM_valid
);

    localparam int NUM_LINES = 2 ** INDEX_BITS;
    localparam int TAG_BITS  = 27 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB      = 3'd1,
        S_REFILL  = 3'd2,
        S_FL_SCAN = 3'd3,
        S_FL_WB   = 3'd4
    } state_e;

    // Big-endian lane merge: lane k..k+n-1 take the n low bytes of wdata, lanes past 3 dropped.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
        logic [31:0] word;
        logic [2:0]  n;
        logic [2:0]  pos;
        logic [2:0]  src;
        word = old_word;
        n    = (size == 2'd0) ? 3'd4 : {1'b0, size};
        for (int l = 0; l < 4; l++) begin
            pos = 3'(l);
            if (pos >= {1'b0, lane} && (pos - {1'b0, lane}) < n) begin
                src = n - 3'd1 - (pos - {1'b0, lane});
                word[31 - 8*l -: 8] = wdata[8*src +: 8];
            end else begin
                word[31 - 8*l -: 8] = old_word[31 - 8*l -: 8];
            end
        end
        return word;
    endfunction

    state_e                  state_q, state_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [NUM_LINES-1:0]    dirty_q, dirty_d;
    logic [INDEX_BITS-1:0]   flush_idx_q, flush_idx_d;
    logic                    flush_done_q, flush_done_d;
    logic [TAG_BITS-1:0]     tag_mem_q  [NUM_LINES];
    logic [255:0]            data_mem_q [NUM_LINES];

    logic [TAG_BITS-1:0]     req_tag_s;
    logic [INDEX_BITS-1:0]   req_idx_s;
    logic [2:0]              req_word_s;
    logic [255:0]            line_s;
    logic [TAG_BITS-1:0]     line_tag_s;
    logic                    hit_s;
    logic                    req_s;
    logic                    serve_s;
    logic [255:0]            line_merged_s;
    logic                    line_we_s;
    logic                    tag_we_s;
    logic [255:0]            line_wdata_s;

    assign req_tag_s  = data_address_2DC[31 -: TAG_BITS];
    assign req_idx_s  = data_address_2DC[5 +: INDEX_BITS];
    assign req_word_s = data_address_2DC[4:2];
    assign line_s     = data_mem_q[req_idx_s];
    assign line_tag_s = tag_mem_q[req_idx_s];
    assign hit_s      = valid_q[req_idx_s] && (line_tag_s == req_tag_s);
    assign req_s      = read_2DC || write_2DC;

    // Hit path: a pending flush holds off any request.
    always_comb begin
        serve_s        = RESET && (state_q == S_IDLE) && !flush_2DC;
        data_valid_fDC = serve_s && (!req_s || hit_s);
        data_read_fDC  = line_s[32*req_word_s +: 32];
        line_merged_s  = line_s;
        line_merged_s[32*req_word_s +: 32] = merge_word(line_s[32*req_word_s +: 32], data_write_2DC,
                                                        data_address_2DC[1:0], data_write_size_2DC);
    end

    // Next-state, line state and array write enables.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        flush_idx_d  = flush_idx_q;
        flush_done_d = 1'b0;
        line_we_s    = 1'b0;
        tag_we_s     = 1'b0;
        line_wdata_s = line_merged_s;
        case (state_q)
            S_IDLE: begin
                if (flush_2DC) begin
                    state_d = S_FL_SCAN;
                end else if (req_s && !hit_s) begin
                    state_d = (valid_q[req_idx_s] && dirty_q[req_idx_s]) ? S_WB : S_REFILL;
                end else if (write_2DC && hit_s) begin
                    line_we_s          = 1'b1;
                    dirty_d[req_idx_s] = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (block_write_fDM_valid) begin
                    state_d = S_REFILL;
                end else begin
                    state_d = S_WB;
                end
            end
            S_REFILL: begin
                if (block_read_fDM_valid) begin
                    line_we_s          = 1'b1;
                    tag_we_s           = 1'b1;
                    line_wdata_s       = block_read_fDM;
                    valid_d[req_idx_s] = 1'b1;
                    dirty_d[req_idx_s] = 1'b0;
                    state_d            = S_IDLE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_FL_SCAN, S_FL_WB: begin
                // A dirty line detours through FL_WB; the index wraps to 0 after the last line.
                if (state_q == S_FL_SCAN && valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
                    state_d = S_FL_WB;
                end else if (state_q == S_FL_SCAN || block_write_fDM_valid) begin
                    valid_d[flush_idx_q] = 1'b0;
                    dirty_d[flush_idx_q] = 1'b0;
                    flush_idx_d          = flush_idx_q + 1'b1;
                    if (flush_idx_q == {INDEX_BITS{1'b1}}) begin
                        state_d      = S_IDLE;
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = S_FL_SCAN;
                    end
                end else begin
                    state_d = S_FL_WB;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            flush_idx_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            flush_idx_q  <= flush_idx_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Tag and data arrays are not reset; writes are suppressed while RESET is low.
    always_ff @(posedge CLK) begin
        if (RESET && line_we_s) begin
            data_mem_q[req_idx_s] <= line_wdata_s;
        end
        if (RESET && tag_we_s) begin
            tag_mem_q[req_idx_s] <= req_tag_s;
        end
    end

    // Memory-side outputs decoded from the registered state.
    always_comb begin
        dBlkRead         = 1'b0;
        dBlkWrite        = 1'b0;
        data_address_2DM = 32'h0000_0000;
        block_write_2DM  = '0;
        flush_done       = RESET && flush_done_q;
        case (state_q)
            S_WB: begin
                dBlkWrite        = RESET;
                data_address_2DM = {line_tag_s, req_idx_s, 5'b00000};
                block_write_2DM  = line_s;
            end
            S_REFILL: begin
                dBlkRead         = RESET;
                data_address_2DM = {data_address_2DC[31:5], 5'b00000};
            end
            S_FL_WB: begin
                dBlkWrite        = RESET;
                data_address_2DM = {tag_mem_q[flush_idx_q], flush_idx_q, 5'b00000};
                block_write_2DM  = data_mem_q[flush_idx_q];
            end
            default: begin
                dBlkRead = 1'b0;
            end
        endcase
    end

    data_cache_dm_chk u_chk (
        .clk      (CLK),
        .rst_n    (RESET),
        .read_req (read_2DC),
        .write_req(write_2DC),
        .blk_rd   (dBlkRead),
        .blk_wr   (dBlkWrite)
    );

endmodule

// Protocol checks for data_cache_dm.
module data_cache_dm_chk (
    input logic clk,
    input logic rst_n,
    input logic read_req,
    input logic write_req,
    input logic blk_rd,
    input logic blk_wr
);

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(read_req && write_req))
        else $error("read_2DC and write_2DC asserted together");

    a_blk_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(blk_rd && blk_wr))
        else $error("dBlkRead and dBlkWrite asserted together");

endmodule
